// File: rtl/execute_stage.sv
// Y86-64 execute stage: 64-bit ALU (valE), SF/ZF/OF condition-code
// register written only by OPq, and jXX/cmovXX condition evaluation
// against the flags left by the most recent earlier OPq.
module execute_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic [63:0] valE,
  output logic        cond,
  output logic        sf,
  output logic        zf,
  output logic        of
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  logic sf_q, zf_q, of_q;
  logic sf_d, zf_d, of_d;
  logic cc_we;

  // ALU result for every instruction class; stack ops move %rsp by 8
  always_comb begin
    valE = 64'd0;
    case (icode)
      I_CMOV:            valE = valA;
      I_IRMOVQ:          valE = valC;
      I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          4'h0:    valE = valB + valA;
          4'h1:    valE = valB - valA;
          4'h2:    valE = valB & valA;
          4'h3:    valE = valB ^ valA;
          default: valE = 64'd0;
        endcase
      end
      I_CALL, I_PUSHQ:   valE = valB - 64'd8;
      I_RET, I_POPQ:     valE = valB + 64'd8;
      default:           valE = 64'd0;
    endcase
  end

  // Flag values produced by this cycle's OPq; only valid OPq functions write them
  always_comb begin
    cc_we = (icode == I_OPQ) && (ifun[3:2] == 2'b00);
    zf_d  = (valE == 64'd0);
    sf_d  = valE[63];
    of_d  = 1'b0;
    case (ifun)
      4'h0:    of_d = (valA[63] == valB[63]) && (valE[63] != valB[63]);
      4'h1:    of_d = (valA[63] != valB[63]) && (valE[63] != valB[63]);
      default: of_d = 1'b0;
    endcase
  end

  // Condition-code register; reset clears it regardless of the clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sf_q <= 1'b0;
      zf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_we) begin
      sf_q <= sf_d;
      zf_q <= zf_d;
      of_q <= of_d;
    end
  end

  // Branch / conditional-move condition from the registered flags
  always_comb begin
    cond = 1'b0;
    if ((icode == I_CMOV) || (icode == I_JXX)) begin
      case (ifun)
        4'h0:    cond = 1'b1;
        4'h1:    cond = (sf_q ^ of_q) | zf_q;
        4'h2:    cond = sf_q ^ of_q;
        4'h3:    cond = zf_q;
        4'h4:    cond = ~zf_q;
        4'h5:    cond = ~(sf_q ^ of_q);
        4'h6:    cond = ~(sf_q ^ of_q) & ~zf_q;
        default: cond = 1'b0;
      endcase
    end
  end

  assign sf = sf_q;
  assign zf = zf_q;
  assign of = of_q;

  // halt/nop take the default zero result
  logic unused_codes;
  assign unused_codes = (I_HALT == I_NOP);

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a scoreboard queue and an
// independent flag model tracking the OPq instructions it drives.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic [3:0]  ifun = 4'h0;
  logic [63:0] valA = 64'd0;
  logic [63:0] valB = 64'd0;
  logic [63:0] valC = 64'd0;
  logic [63:0] valE;
  logic        cond, sf, zf, of;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [63:0] e;
    logic        c;
    logic        s;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];

  logic m_sf, m_zf, m_of;

  execute_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .cond  (cond),
    .sf    (sf),
    .zf    (zf),
    .of    (of)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_opq(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    if (fn == 4'h0) return b + a;
    if (fn == 4'h1) return b - a;
    if (fn == 4'h2) return b & a;
    if (fn == 4'h3) return b ^ a;
    return 64'd0;
  endfunction

  // overflow from a 65-bit sign-extended computation
  function automatic logic ref_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    if (fn == 4'h0) w = {b[63], b} + {a[63], a};
    else if (fn == 4'h1) w = {b[63], b} - {a[63], a};
    else return 1'b0;
    return w[64] != w[63];
  endfunction

  function automatic logic ref_cond(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic s, input logic z, input logic o);
    logic lt;
    if (!(ic == 4'h2 || ic == 4'h7)) return 1'b0;
    lt = (s != o);
    case (fn)
      4'h0: return 1'b1;
      4'h1: return lt || z;
      4'h2: return lt;
      4'h3: return z;
      4'h4: return !z;
      4'h5: return !lt;
      4'h6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  // reference flag register driven only by the bench's own inputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sf <= 1'b0;
      m_zf <= 1'b0;
      m_of <= 1'b0;
    end else if (icode == 4'h6 && ifun < 4'h4) begin
      m_zf <= (ref_opq(ifun, valA, valB) == 64'd0);
      m_sf <= ref_opq(ifun, valA, valB) >> 63;
      m_of <= ref_of(ifun, valA, valB);
    end
  end

  task automatic compare_pop();
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (valE === e.e) else begin
      miscompares++;
      $error("FAIL %s valE observed=%h expected=%h", e.tag, valE, e.e);
    end
    vectors++;
    assert (cond === e.c) else begin
      miscompares++;
      $error("FAIL %s cond observed=%b expected=%b", e.tag, cond, e.c);
    end
    vectors++;
    assert ({sf, zf, of} === {e.s, e.z, e.o}) else begin
      miscompares++;
      $error("FAIL %s flags(sf,zf,of) observed=%b%b%b expected=%b%b%b",
             e.tag, sf, zf, of, e.s, e.z, e.o);
    end
  endtask

  task automatic apply(input string tag, input bit sync, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] ev, input logic ec);
    if (sync) @(negedge clk);
    icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    #1;
    sb.push_back('{tag, ev, ec, m_sf, m_zf, m_of});
    #1;
    compare_pop();
  endtask

  task automatic check_flags(input string tag, input logic s, input logic z, input logic o);
    vectors++;
    assert ({sf, zf, of} === {s, z, o}) else begin
      miscompares++;
      $error("FAIL %s flags(sf,zf,of) observed=%b%b%b expected=%b%b%b", tag, sf, zf, of, s, z, o);
    end
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [3:0]  rf, ric;
    rst_n = 1'b0;
    #2;
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("irmovq", 1, 4'h3, 4'h0, 64'd0, 64'd0, 64'hAA11223344556677, 64'hAA11223344556677, 1'b0);
    check_flags("irmovq_flags", 1'b0, 1'b0, 1'b0);
    apply("add", 1, 4'h6, 4'h0, 64'h1122334455667788, 64'h99AABBCCDDEEFF00, 64'd0,
          64'hAACCEF1133557688, 1'b0);
    check_flags("add_pre_edge", 1'b0, 1'b0, 1'b0);
    apply("cmovle", 1, 4'h2, 4'h1, 64'h019282A9729F982C, 64'd0, 64'd0, 64'h019282A9729F982C, 1'b1);
    check_flags("add_flags", 1'b1, 1'b0, 1'b0);

    apply("sub_eq", 1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b0);
    apply("jle_z", 1, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    check_flags("sub_flags", 1'b0, 1'b1, 1'b0);
    apply("jg_z", 1, 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    apply("je_z", 1, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    apply("jne_z", 1, 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);

    apply("add_ovf", 1, 4'h6, 4'h0, 64'd1, 64'h7FFFFFFFFFFFFFFF, 64'd0, 64'h8000000000000000, 1'b0);
    apply("jl_ovf", 1, 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    check_flags("ovf_flags", 1'b1, 1'b0, 1'b1);
    apply("jge_ovf", 1, 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    apply("jmp", 1, 4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1);
    apply("j_fn7", 1, 4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    apply("irmov_nocond", 1, 4'h3, 4'h0, 64'd0, 64'd0, 64'h5, 64'h5, 1'b0);

    // asynchronous reset between edges, then an edge while held in reset
    rst_n = 1'b0;
    #1;
    check_flags("async_rst", 1'b0, 1'b0, 1'b0);
    apply("jle_rst", 0, 4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    apply("sub_in_rst", 0, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    @(posedge clk);
    #1;
    check_flags("edge_in_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("sub_neg", 0, 4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    apply("call", 1, 4'h8, 4'h0, 64'd0, 64'h99AABBCCDDEEFF09, 64'd0, 64'h99AABBCCDDEEFF01, 1'b0);
    apply("ret_wrap", 1, 4'h9, 4'h0, 64'd0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 64'd0, 1'b0);
    check_flags("call_hold", 1'b1, 1'b0, 1'b0);
    apply("pushq", 1, 4'hA, 4'h0, 64'd0, 64'h1000, 64'd0, 64'h0FF8, 1'b0);
    apply("popq", 1, 4'hB, 4'h0, 64'd0, 64'h1000, 64'd0, 64'h1008, 1'b0);
    apply("rmmovq", 1, 4'h4, 4'h0, 64'd0, 64'h1000, 64'h24, 64'h1024, 1'b0);
    apply("mrmovq", 1, 4'h5, 4'h0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1, 1'b0);
    apply("and", 1, 4'h6, 4'h2, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'd0,
          64'hF000F000F000F000, 1'b0);
    apply("xor", 1, 4'h6, 4'h3, 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 64'd0, 64'd0, 1'b0);
    apply("opq_bad", 1, 4'h6, 4'h4, 64'd3, 64'd4, 64'd0, 64'd0, 1'b0);
    check_flags("xor_flags", 1'b0, 1'b1, 1'b0);
    apply("invalid_c", 1, 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0);
    check_flags("opq_bad_hold", 1'b0, 1'b1, 1'b0);
    apply("nop", 1, 4'h1, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0);
    apply("halt", 1, 4'h0, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0);

    // random OPq followed by random cmov/jXX, expectations from the model
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 0) rb = ra;
      rf = 4'($urandom_range(0, 3));
      apply("rand_opq", 1, 4'h6, rf, ra, rb, 64'd0, ref_opq(rf, ra, rb), 1'b0);
      ric = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'h7;
      rf = 4'($urandom_range(0, 7));
      @(negedge clk);
      icode = ric; ifun = rf; valA = ra; valB = rb;
      #1;
      sb.push_back('{"rand_cond", (ric == 4'h2) ? ra : 64'd0,
                     ref_cond(ric, rf, m_sf, m_zf, m_of), m_sf, m_zf, m_of});
      #1;
      compare_pop();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
